// File: rtl/can_sched_pkg.sv
// rtl/can_sched_pkg.sv - shared state type and sizing helper for the CAN TX mailbox scheduler
package can_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PICK    = 3'd1,
        ST_LOAD    = 3'd2,
        ST_ACTIVE  = 3'd3,
        ST_REQUEUE = 3'd4
    } sched_state_e;

    // Width of a mailbox index; never narrower than one bit.
    function automatic int sel_w(input int num_mbox);
        return (num_mbox > 1) ? $clog2(num_mbox) : 1;
    endfunction

endpackage

// File: rtl/can_tx_sched_if.sv
// rtl/can_tx_sched_if.sv - mailbox and arbitration-controller signals of the CAN TX scheduler
interface can_tx_sched_if import can_sched_pkg::*; #(
    parameter int NUM_MBOX = 4,
    parameter int ID_W     = 29,
    parameter int RETRY_W  = 8
);
    logic [NUM_MBOX-1:0]         mbox_req;
    logic [NUM_MBOX*ID_W-1:0]    mbox_id;
    logic [NUM_MBOX-1:0]         mbox_abort;
    logic                        arbtr_sts;
    logic                        msg_due_tx;
    logic                        txed_lst_bit_ifs;
    logic                        tx_buff_busy;
    logic [sel_w(NUM_MBOX)-1:0]  tx_sel;
    logic                        tx_load;
    logic [NUM_MBOX-1:0]         mbox_done;
    logic [NUM_MBOX-1:0]         mbox_aborted;
    logic [NUM_MBOX-1:0]         mbox_fail;
    logic [RETRY_W-1:0]          retry_cnt;

    modport master (
        output mbox_req, mbox_id, mbox_abort, arbtr_sts, msg_due_tx, txed_lst_bit_ifs,
        input  tx_buff_busy, tx_sel, tx_load, mbox_done, mbox_aborted, mbox_fail, retry_cnt
    );

    modport slave (
        input  mbox_req, mbox_id, mbox_abort, arbtr_sts, msg_due_tx, txed_lst_bit_ifs,
        output tx_buff_busy, tx_sel, tx_load, mbox_done, mbox_aborted, mbox_fail, retry_cnt
    );
endinterface

// File: rtl/can_tx_prio_sel.sv
// rtl/can_tx_prio_sel.sv - combinational lowest-identifier winner over the eligible mailboxes
module can_tx_prio_sel import can_sched_pkg::*; #(
    parameter int NUM_MBOX = 4,
    parameter int ID_W     = 29
) (
    input  logic [NUM_MBOX-1:0]        elig_i,
    input  logic [NUM_MBOX*ID_W-1:0]   id_i,
    output logic                       vld_o,
    output logic [sel_w(NUM_MBOX)-1:0] idx_o
);
    localparam int SEL_W  = sel_w(NUM_MBOX);
    localparam int LEAVES = 1 << SEL_W;

    // Heap-ordered tree: node n combines 2n and 2n+1, leaves sit at LEAVES+i.
    logic             node_v  [1:2*LEAVES-1];
    logic [ID_W-1:0]  node_id [1:2*LEAVES-1];
    logic [SEL_W-1:0] node_ix [1:2*LEAVES-1];

    always_comb begin
        for (int n = 1; n < 2 * LEAVES; n++) begin
            node_v[n]  = 1'b0;
            node_id[n] = '0;
            node_ix[n] = '0;
        end
        for (int i = 0; i < LEAVES; i++) begin
            node_ix[LEAVES + i] = SEL_W'(i);
            if (i < NUM_MBOX) begin
                node_v[LEAVES + i]  = elig_i[i];
                node_id[LEAVES + i] = id_i[i*ID_W +: ID_W];
            end
        end
        // Left child wins ties, so equal identifiers resolve to the lower index.
        for (int n = LEAVES - 1; n >= 1; n--) begin
            if (node_v[2*n] && (!node_v[2*n+1] || node_id[2*n] <= node_id[2*n+1])) begin
                node_v[n]  = node_v[2*n];
                node_id[n] = node_id[2*n];
                node_ix[n] = node_ix[2*n];
            end else begin
                node_v[n]  = node_v[2*n+1];
                node_id[n] = node_id[2*n+1];
                node_ix[n] = node_ix[2*n+1];
            end
        end
        vld_o = node_v[1];
        idx_o = node_ix[1];
    end
endmodule

// File: rtl/can_tx_sched.sv
// rtl/can_tx_sched.sv - CAN TX mailbox scheduler: picks, loads, retries and retires frames
module can_tx_sched import can_sched_pkg::*; #(
    parameter int NUM_MBOX  = 4,
    parameter int ID_W      = 29,
    parameter int RETRY_W   = 8,
    parameter int MAX_RETRY = 128
) (
    input  logic          osc_clk,
    input  logic          g_rst_n,
    can_tx_sched_if.slave bus
);
    localparam int SEL_W = sel_w(NUM_MBOX);

    sched_state_e        state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [RETRY_W-1:0]  retry_q, retry_d, retry_inc;
    logic                tx_load_q, tx_load_d, busy_q, busy_d, due_q;
    logic [NUM_MBOX-1:0] excl_q, excl_d, pend_q, pend_d;
    logic [NUM_MBOX-1:0] done_q, done_d, abrt_q, abrt_d, fail_q, fail_d;
    logic [NUM_MBOX-1:0] abort_now, elig, sel_oh, inflight, set_excl;
    logic                win_vld, due_rise;
    logic [SEL_W-1:0]    win_idx;

    // A mailbox with an abort outstanding is never handed to the picker.
    assign abort_now = bus.mbox_abort | pend_q;
    assign elig      = bus.mbox_req & ~excl_q & ~abort_now;
    assign sel_oh    = {{(NUM_MBOX-1){1'b0}}, 1'b1} << sel_q;
    assign inflight  = (state_q inside {ST_LOAD, ST_ACTIVE, ST_REQUEUE}) ? sel_oh : '0;
    assign due_rise  = bus.msg_due_tx & ~due_q;
    assign retry_inc = (&retry_q) ? retry_q : retry_q + 1'b1;

    can_tx_prio_sel #(.NUM_MBOX(NUM_MBOX), .ID_W(ID_W)) u_prio (
        .elig_i (elig),
        .id_i   (bus.mbox_id),
        .vld_o  (win_vld),
        .idx_o  (win_idx)
    );

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        retry_d   = retry_q;
        tx_load_d = 1'b0;
        done_d    = '0;
        fail_d    = '0;
        abrt_d    = bus.mbox_abort & ~inflight;
        set_excl  = abrt_d;
        pend_d    = pend_q | (bus.mbox_abort & inflight);
        unique case (state_q)
            ST_IDLE: begin
                if (|elig) state_d = ST_PICK;
            end
            ST_PICK: begin
                if (win_vld) begin
                    if (win_idx != sel_q) retry_d = '0;
                    sel_d     = win_idx;
                    tx_load_d = 1'b1;
                    state_d   = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: state_d = ST_ACTIVE;
            ST_ACTIVE: begin
                if (bus.txed_lst_bit_ifs) begin
                    done_d   = sel_oh;
                    set_excl = set_excl | sel_oh;
                    retry_d  = '0;
                    pend_d   = '0;
                    state_d  = ST_IDLE;
                end else if (due_rise) begin
                    retry_d = retry_inc;
                    if (|(abort_now & sel_oh)) begin
                        abrt_d   = abrt_d | sel_oh;
                        set_excl = set_excl | sel_oh;
                        pend_d   = '0;
                        state_d  = ST_IDLE;
                    end else if (MAX_RETRY != 0 && retry_inc == RETRY_W'(MAX_RETRY)) begin
                        fail_d   = sel_oh;
                        set_excl = set_excl | sel_oh;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d = ST_REQUEUE;
                    end
                end
            end
            ST_REQUEUE: begin
                if (|(abort_now & sel_oh)) begin
                    abrt_d   = abrt_d | sel_oh;
                    set_excl = set_excl | sel_oh;
                    pend_d   = '0;
                    state_d  = ST_IDLE;
                end else if (bus.arbtr_sts) begin
                    state_d = ST_PICK;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Busy covers a loaded or still-due frame, including the re-pick after a loss.
        busy_d = (state_q != ST_IDLE) && (state_d != ST_IDLE);
        excl_d = (excl_q | set_excl) & bus.mbox_req;
    end

    always_ff @(posedge osc_clk) begin
        if (!g_rst_n) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            retry_q   <= '0;
            tx_load_q <= 1'b0;
            busy_q    <= 1'b0;
            due_q     <= 1'b0;
            excl_q    <= '0;
            pend_q    <= '0;
            done_q    <= '0;
            abrt_q    <= '0;
            fail_q    <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            retry_q   <= retry_d;
            tx_load_q <= tx_load_d;
            busy_q    <= busy_d;
            due_q     <= bus.msg_due_tx;
            excl_q    <= excl_d;
            pend_q    <= pend_d;
            done_q    <= done_d;
            abrt_q    <= abrt_d;
            fail_q    <= fail_d;
        end
    end

    assign bus.tx_buff_busy = busy_q;
    assign bus.tx_sel       = sel_q;
    assign bus.tx_load      = tx_load_q;
    assign bus.mbox_done    = done_q;
    assign bus.mbox_aborted = abrt_q;
    assign bus.mbox_fail    = fail_q;
    assign bus.retry_cnt    = retry_q;
endmodule

// File: tb/tb_can_tx_sched.sv
// tb/tb_can_tx_sched.sv - self-checking bench for can_tx_sched against a frame-lifecycle reference model
module tb_can_tx_sched;
    localparam int NMB  = 4;
    localparam int IDW  = 29;
    localparam int RW   = 8;
    localparam int MAXR = 3;

    logic clk = 1'b0;
    logic g_rst_n;
    int   n_cmp = 0;
    int   n_mis = 0;

    can_tx_sched_if #(.NUM_MBOX(NMB), .ID_W(IDW), .RETRY_W(RW)) bus ();

    can_tx_sched #(.NUM_MBOX(NMB), .ID_W(IDW), .RETRY_W(RW), .MAX_RETRY(MAXR)) dut (
        .osc_clk (clk),
        .g_rst_n (g_rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference model: where the current frame is in its life, plus expected outputs.
    bit           m_pick, m_loading, m_onbus, m_wait;
    bit           m_busy, m_load, m_due_prev;
    int           m_sel, m_retry;
    bit [NMB-1:0] m_done, m_abrt, m_fail, m_excl, m_pend;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [IDW-1:0] id_of(input int i);
        return bus.mbox_id[i*IDW +: IDW];
    endfunction

    task automatic model_step();
        bit [NMB-1:0] r, ab, a, elig, setx, selb;
        bit infl, was_idle, rise;
        int best;
        if (!g_rst_n) begin
            {m_pick, m_loading, m_onbus, m_wait, m_busy, m_load, m_due_prev} = '0;
            m_sel = 0; m_retry = 0;
            m_done = '0; m_abrt = '0; m_fail = '0; m_excl = '0; m_pend = '0;
            return;
        end
        r    = bus.mbox_req;
        ab   = bus.mbox_abort;
        infl = m_loading | m_onbus | m_wait;
        selb = infl ? (NMB'(1) << m_sel) : '0;
        a    = ab | m_pend;
        elig = r & ~m_excl & ~a;
        rise = bus.msg_due_tx && !m_due_prev;
        was_idle = !(m_pick | infl);
        m_done = '0; m_fail = '0; m_load = 0;
        m_abrt = ab & ~selb;
        setx   = m_abrt;
        m_pend = m_pend | (ab & selb);
        if (m_pick) begin
            best = -1;
            for (int i = 0; i < NMB; i++)
                if (elig[i] && (best < 0 || id_of(i) < id_of(best))) best = i;
            m_pick = 0;
            if (best >= 0) begin
                if (best != m_sel) m_retry = 0;
                m_sel = best; m_load = 1; m_loading = 1;
            end
        end else if (m_loading) begin
            m_loading = 0; m_onbus = 1;
        end else if (m_onbus) begin
            if (bus.txed_lst_bit_ifs) begin
                m_done[m_sel] = 1; setx[m_sel] = 1; m_retry = 0; m_pend = '0; m_onbus = 0;
            end else if (rise) begin
                if (m_retry < (1 << RW) - 1) m_retry++;
                m_onbus = 0;
                if (a[m_sel]) begin
                    m_abrt[m_sel] = 1; setx[m_sel] = 1; m_pend = '0;
                end else if (MAXR != 0 && m_retry == MAXR) begin
                    m_fail[m_sel] = 1; setx[m_sel] = 1;
                end else begin
                    m_wait = 1;
                end
            end
        end else if (m_wait) begin
            if (a[m_sel]) begin
                m_abrt[m_sel] = 1; setx[m_sel] = 1; m_pend = '0; m_wait = 0;
            end else if (bus.arbtr_sts) begin
                m_wait = 0; m_pick = 1;
            end
        end else if (elig != '0) begin
            m_pick = 1;
        end
        m_busy     = !was_idle && (m_pick | m_loading | m_onbus | m_wait);
        m_excl     = (m_excl | setx) & r;
        m_due_prev = bus.msg_due_tx;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_eq("busy",    32'(bus.tx_buff_busy), 32'(m_busy));
        check_eq("load",    32'(bus.tx_load),      32'(m_load));
        check_eq("sel",     32'(bus.tx_sel),       32'(m_sel));
        check_eq("done",    32'(bus.mbox_done),    32'(m_done));
        check_eq("aborted", 32'(bus.mbox_aborted), 32'(m_abrt));
        check_eq("fail",    32'(bus.mbox_fail),    32'(m_fail));
        check_eq("retry",   32'(bus.retry_cnt),    32'(m_retry));
    endtask

    task automatic quiet();
        bus.mbox_req = '0; bus.mbox_abort = '0; bus.arbtr_sts = 0;
        bus.msg_due_tx = 0; bus.txed_lst_bit_ifs = 0;
    endtask

    task automatic set_id(input int i, input logic [IDW-1:0] v);
        bus.mbox_id[i*IDW +: IDW] = v;
    endtask

    task automatic wait_load();
        int n = 0;
        while (bus.tx_load !== 1'b1 && n < 40) begin tick(); n++; end
        check_eq("load_seen", 32'(bus.tx_load), 32'd1);
    endtask

    // Called in the LOAD cycle: go on bus, then report success.
    task automatic finish_frame(input int exp_sel);
        tick();
        bus.txed_lst_bit_ifs = 1; tick(); bus.txed_lst_bit_ifs = 0;
        check_eq("done_mask", 32'(bus.mbox_done), 32'(1 << exp_sel));
        check_eq("busy_after_done", 32'(bus.tx_buff_busy), 32'd0);
    endtask

    task automatic serve(input int exp_sel);
        wait_load();
        check_eq("served_sel", 32'(bus.tx_sel), 32'(exp_sel));
        finish_frame(exp_sel);
    endtask

    initial begin
        int nl;
        g_rst_n = 0; quiet(); bus.mbox_id = '0;
        tick(); tick();
        check_eq("rst_busy", 32'(bus.tx_buff_busy), 32'd0);
        check_eq("rst_retry", 32'(bus.retry_cnt), 32'd0);
        g_rst_n = 1;

        // single request: PICK in cycle 1, load in cycle 2
        set_id(0, 29'h100); bus.mbox_req = 4'b0001;
        tick(); check_eq("c1_no_load", 32'(bus.tx_load), 32'd0);
        tick(); check_eq("c2_load", 32'(bus.tx_load), 32'd1);
        check_eq("c2_busy", 32'(bus.tx_buff_busy), 32'd1);
        check_eq("c2_sel", 32'(bus.tx_sel), 32'd0);
        finish_frame(0);
        bus.mbox_req = '0; tick();

        // priority by id, then ties by index
        set_id(1, 29'h200); set_id(3, 29'h050); bus.mbox_req = 4'b1010;
        serve(3); serve(1);
        bus.mbox_req = '0; tick();
        set_id(0, 29'h077); set_id(2, 29'h077); bus.mbox_req = 4'b0101;
        serve(0); serve(2);
        bus.mbox_req = '0; tick();

        // arbitration loss, then preemption by a higher-priority arrival
        set_id(2, 29'h300); set_id(0, 29'h010); bus.mbox_req = 4'b0100;
        wait_load(); tick();
        bus.msg_due_tx = 1; tick();
        check_eq("loss_retry", 32'(bus.retry_cnt), 32'd1);
        check_eq("loss_busy", 32'(bus.tx_buff_busy), 32'd1);
        bus.mbox_req = 4'b0101; tick();
        bus.arbtr_sts = 1; bus.msg_due_tx = 0; tick();
        bus.arbtr_sts = 0; tick();
        check_eq("preempt_load", 32'(bus.tx_load), 32'd1);
        check_eq("preempt_sel", 32'(bus.tx_sel), 32'd0);
        check_eq("preempt_retry", 32'(bus.retry_cnt), 32'd0);
        finish_frame(0); serve(2);
        bus.mbox_req = '0; tick();

        // retry exhaustion at MAXR losses
        set_id(1, 29'h005); bus.mbox_req = 4'b0010;
        wait_load(); tick();
        for (int k = 1; k <= MAXR; k++) begin
            bus.msg_due_tx = 1; tick(); bus.msg_due_tx = 0;
            if (k < MAXR) begin
                check_eq("retry_step", 32'(bus.retry_cnt), 32'(k));
                bus.arbtr_sts = 1; tick(); bus.arbtr_sts = 0;
                wait_load(); tick();
            end else begin
                check_eq("fail_mask", 32'(bus.mbox_fail), 32'b0010);
                check_eq("fail_busy", 32'(bus.tx_buff_busy), 32'd0);
            end
        end
        nl = 0;
        repeat (6) begin tick(); nl += int'(bus.tx_load); end
        check_eq("no_reload_after_fail", 32'(nl), 32'd0);
        bus.mbox_req = '0; tick();
        bus.mbox_req = 4'b0010; serve(1);
        bus.mbox_req = '0; tick();

        // aborts: idle pending mailbox, deferred-then-success, deferred-then-loss
        set_id(0, 29'h010); set_id(3, 29'h400); bus.mbox_req = 4'b1001;
        wait_load(); tick();
        bus.mbox_abort = 4'b1000; tick(); bus.mbox_abort = '0;
        check_eq("abort_idle", 32'(bus.mbox_aborted), 32'b1000);
        bus.mbox_abort = 4'b0001; tick(); bus.mbox_abort = '0;
        check_eq("abort_deferred", 32'(bus.mbox_aborted), 32'd0);
        bus.txed_lst_bit_ifs = 1; tick(); bus.txed_lst_bit_ifs = 0;
        check_eq("abort_then_done", 32'(bus.mbox_done), 32'b0001);
        check_eq("abort_then_done_ab", 32'(bus.mbox_aborted), 32'd0);
        bus.mbox_req = '0; tick();
        set_id(2, 29'h030); bus.mbox_req = 4'b0100;
        wait_load(); tick();
        bus.mbox_abort = 4'b0100; tick(); bus.mbox_abort = '0;
        bus.msg_due_tx = 1; tick(); bus.msg_due_tx = 0;
        check_eq("abort_on_loss", 32'(bus.mbox_aborted), 32'b0100);
        check_eq("abort_on_loss_busy", 32'(bus.tx_buff_busy), 32'd0);
        bus.mbox_req = '0; tick();

        // reset mid-frame with a nonzero retry count
        set_id(1, 29'h009); bus.mbox_req = 4'b0010;
        wait_load(); tick();
        bus.msg_due_tx = 1; tick(); bus.msg_due_tx = 0;
        bus.arbtr_sts = 1; tick(); bus.arbtr_sts = 0;
        wait_load(); tick();
        check_eq("pre_reset_retry", 32'(bus.retry_cnt), 32'd1);
        g_rst_n = 0; tick(); g_rst_n = 1;
        check_eq("reset_busy", 32'(bus.tx_buff_busy), 32'd0);
        check_eq("reset_retry", 32'(bus.retry_cnt), 32'd0);
        check_eq("reset_pulses", 32'(bus.mbox_done | bus.mbox_aborted | bus.mbox_fail), 32'd0);
        wait_load();
        check_eq("repick_sel", 32'(bus.tx_sel), 32'd1);
        check_eq("repick_retry", 32'(bus.retry_cnt), 32'd0);
        finish_frame(1);
        bus.mbox_req = '0; tick();

        // randomized traffic against the model
        quiet();
        for (int i = 0; i < NMB; i++) set_id(i, IDW'($urandom_range(0, 7)));
        for (int c = 0; c < 3000; c++) begin
            int k;
            k = $urandom_range(0, NMB - 1);
            if ($urandom_range(0, 15) == 0) bus.mbox_req[k] = ~bus.mbox_req[k];
            k = $urandom_range(0, NMB - 1);
            if ($urandom_range(0, 31) == 0) set_id(k, IDW'($urandom_range(0, 7)));
            k = $urandom_range(0, NMB - 1);
            bus.mbox_abort = ($urandom_range(0, 31) == 0) ? (NMB'(1) << k) : '0;
            bus.arbtr_sts = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) bus.msg_due_tx = ~bus.msg_due_tx;
            bus.txed_lst_bit_ifs = ($urandom_range(0, 9) == 0);
            g_rst_n = ($urandom_range(0, 499) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
